// File: rtl/dg0045_rom_responder.sv
// DG0045 program-memory responder: reassembles the 2x5-bit multiplexed PC, returns the
// instruction byte from host-loaded RAM. Optional parity: define DG0045_ROM_PARITY_EN.
module dg0045_rom_responder #(
  parameter int DEPTH = 256,
  parameter int AW    = 10
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic [4:0] pc_hl,
  input  logic       pc_mux,
  output logic [7:0] rom_data,
  output logic       rom_valid,
  output logic       addr_err,
  output logic       par_err,
  input  logic       ld_valid,
  output logic       ld_ready,
  input  logic [9:0] ld_addr,
  input  logic [7:0] ld_data
);

  localparam int IW = $clog2(DEPTH);
  localparam logic [AW:0] DEPTH_L = (AW+1)'(DEPTH);
`ifdef DG0045_ROM_PARITY_EN
  localparam int DW = 9;
`else
  localparam int DW = 8;
`endif

  typedef enum logic [1:0] {IDLE, GOT_LO, LOOKUP, DRIVE} state_t;

  state_t          state, state_nx;
  logic            cap_lo, cap_hi, do_rd, do_drv, clr_vld;
  logic            fresh;
  logic [4:0]      lo, hi;
  logic [AW-1:0]   fetch_addr;
  logic            rd_in, rd_oor, wr_go, wr_in, par_bad;
  logic [IW-1:0]   rd_idx, wr_idx;
  logic [DW-1:0]   wr_word, rd_word;
  logic [DW-1:0]   mem [DEPTH];

  assign fetch_addr = {hi, lo};
  assign rd_in      = {1'b0, fetch_addr} < DEPTH_L;
  assign wr_in      = {1'b0, ld_addr} < DEPTH_L;
  assign rd_idx     = rd_in ? fetch_addr[IW-1:0] : '0;
  assign wr_idx     = wr_in ? ld_addr[IW-1:0] : '0;
  assign wr_go      = ena & ld_valid & ld_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else if (ena) state <= state_nx;
  end

  // A new low half always restarts the fetch, even before the previous word is shown.
  always_comb begin
    state_nx = state;
    cap_lo   = 1'b0;
    cap_hi   = 1'b0;
    do_rd    = 1'b0;
    do_drv   = 1'b0;
    clr_vld  = 1'b0;
    ld_ready = (state != LOOKUP);
    case (state)
      IDLE, DRIVE: begin
        if (!pc_mux) begin
          cap_lo   = 1'b1;
          clr_vld  = 1'b1;
          state_nx = GOT_LO;
        end else if (state == DRIVE && fresh) begin
          do_drv = 1'b1;
        end
      end
      GOT_LO: begin
        if (pc_mux) begin
          cap_hi   = 1'b1;
          state_nx = LOOKUP;
        end else begin
          cap_lo = 1'b1;
        end
      end
      LOOKUP: begin
        do_rd    = 1'b1;
        state_nx = DRIVE;
      end
      default: state_nx = IDLE;
    endcase
  end

`ifdef DG0045_ROM_PARITY_EN
  assign wr_word = {^ld_data, ld_data};
  assign par_bad = ^rd_word;
`else
  assign wr_word = ld_data;
  assign par_bad = 1'b0;
`endif

  // Program RAM is deliberately not reset; one shared port, read only in LOOKUP.
  always_ff @(posedge clk) begin
    if (wr_go && wr_in) mem[wr_idx] <= wr_word;
    if (ena && do_rd) rd_word <= mem[rd_idx];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fresh     <= 1'b0;
      lo        <= '0;
      hi        <= '0;
      rd_oor    <= 1'b0;
      rom_data  <= 8'h00;
      rom_valid <= 1'b0;
      addr_err  <= 1'b0;
    end else if (ena) begin
      fresh    <= do_rd;
      addr_err <= (do_drv & rd_oor) | (wr_go & ~wr_in);
      if (cap_lo) lo <= pc_hl;
      if (cap_hi) hi <= pc_hl;
      if (do_rd) rd_oor <= ~rd_in;
      if (clr_vld) begin
        rom_valid <= 1'b0;
      end else if (do_drv) begin
        rom_valid <= 1'b1;
        rom_data  <= (rd_oor || par_bad) ? 8'h00 : rd_word[7:0];
      end
    end
  end

`ifdef DG0045_ROM_PARITY_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) par_err <= 1'b0;
    else if (ena) par_err <= do_drv & ~rd_oor & par_bad;
  end
`else
  assign par_err = 1'b0;
`endif

endmodule

// File: tb/tb_dg0045_rom_responder.sv
// Randomized bench for dg0045_rom_responder against a transaction-level memory model.
module tb_dg0045_rom_responder;
  localparam int DEPTH = 256;

  logic       clk = 1'b0;
  logic       rst_n, ena, pc_mux, ld_valid;
  logic [4:0] pc_hl;
  logic [9:0] ld_addr;
  logic [7:0] ld_data;
  logic [7:0] rom_data;
  logic       rom_valid, addr_err, par_err, ld_ready;

  logic [7:0] model [1024];
  int n_chk = 0;
  int n_err = 0;

  dg0045_rom_responder #(.DEPTH(DEPTH), .AW(10)) dut (
    .clk(clk), .rst_n(rst_n), .ena(ena), .pc_hl(pc_hl), .pc_mux(pc_mux),
    .rom_data(rom_data), .rom_valid(rom_valid), .addr_err(addr_err), .par_err(par_err),
    .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_addr(ld_addr), .ld_data(ld_data)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk); #1;
  endtask

  // One clock; with a held load request, the model absorbs the write only when the port is free.
  task automatic sstep(input bit hold, input bit rdy);
    if (hold) chk("ld_ready", 32'(ld_ready), 32'(rdy));
    step();
    if (hold && rdy && ena) begin
      model[ld_addr] = ld_data;
      ld_addr = 10'((int'(ld_addr) + 1) % DEPTH);
      ld_data = 8'($urandom);
    end
  endtask

  task automatic load(input int a, input logic [7:0] d);
    ld_valid = 1'b1; ld_addr = 10'(a); ld_data = d;
    chk("ld_rdy", 32'(ld_ready), 32'd1);
    step();
    if (a < DEPTH) model[a] = d;
    chk("ld_aerr", 32'(addr_err), 32'(a >= DEPTH));
    ld_valid = 1'b0;
  endtask

  task automatic fetch(input int a, input int nlo, input int gap, input bit hold, input bit pbad);
    logic [9:0] av;
    logic [7:0] exp_d;
    bit oor;
    av = 10'(a);
    for (int i = 0; i < nlo; i++) begin
      pc_mux = 1'b0;
      pc_hl  = (i == nlo - 1) ? av[4:0] : 5'($urandom);
      sstep(hold, 1'b1);
      chk("vld_lo", 32'(rom_valid), 32'd0);
    end
    pc_mux = 1'b1; pc_hl = av[9:5];
    sstep(hold, 1'b1);
    pc_hl = 5'($urandom);
    chk("rdy_lookup", 32'(ld_ready), 32'd0);
    if (gap > 0) begin
      ena = 1'b0;
      for (int g = 0; g < gap; g++) begin
        sstep(hold, 1'b0);
        chk("frz_vld", 32'(rom_valid), 32'd0);
      end
      ena = 1'b1;
    end
    sstep(hold, 1'b0);
    oor   = (a >= DEPTH);
    exp_d = (oor || pbad) ? 8'h00 : model[a];
    chk("vld_e1", 32'(rom_valid), 32'd0);
    sstep(hold, 1'b1);
    chk("vld", 32'(rom_valid), 32'd1);
    chk("data", 32'(rom_data), 32'(exp_d));
    chk("aerr", 32'(addr_err), 32'(oor));
    chk("perr", 32'(par_err), 32'(pbad));
    sstep(hold, 1'b1);
    chk("vld_hold", 32'(rom_valid), 32'd1);
    chk("data_hold", 32'(rom_data), 32'(exp_d));
    chk("aerr_pulse", 32'(addr_err), 32'd0);
    chk("perr_pulse", 32'(par_err), 32'd0);
  endtask

  initial begin
    logic [7:0] old_d;
    rst_n = 1'b0; ena = 1'b1; pc_mux = 1'b1; pc_hl = '0;
    ld_valid = 1'b0; ld_addr = '0; ld_data = '0;
    step(); step();
    chk("rst_data", 32'(rom_data), 32'h00);
    chk("rst_vld", 32'(rom_valid), 32'd0);
    chk("rst_aerr", 32'(addr_err), 32'd0);
    chk("rst_perr", 32'(par_err), 32'd0);
    chk("rst_rdy", 32'(ld_ready), 32'd1);
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) step();
    chk("idle_nofetch", 32'(rom_valid), 32'd0);

    // Fill the whole RAM so any in-range fetch has a known answer.
    ld_valid = 1'b1;
    for (int a = 0; a < DEPTH; a++) begin
      ld_addr = 10'(a); ld_data = 8'($urandom);
      model[a] = ld_data;
      step();
    end
    ld_valid = 1'b0;

    load(37, 8'hA7);
    fetch(37, 1, 0, 1'b0, 1'b0);
    load(0, 8'h5C);
    fetch(10'h3FF, 2, 0, 1'b0, 1'b0);
    load(10'h300, 8'hEE);
    step();
    chk("aerr_clr", 32'(addr_err), 32'd0);
    fetch(0, 1, 0, 1'b0, 1'b0);

    ld_valid = 1'b1; ld_addr = 10'h080; ld_data = 8'($urandom);
    fetch(10'h040, 2, 0, 1'b1, 1'b0);
    ld_valid = 1'b0;
    fetch(10'h081, 1, 0, 1'b0, 1'b0);

    fetch(10'h0C3, 1, 5, 1'b0, 1'b0);

    // Writing the word being driven leaves rom_data alone until the next fetch.
    fetch(10'h055, 1, 0, 1'b0, 1'b0);
    old_d = model[8'h55];
    load(10'h055, ~old_d);
    chk("drv_wr_stable", 32'(rom_data), 32'(old_d));
    fetch(10'h055, 1, 0, 1'b0, 1'b0);

    // Reset while in LOOKUP aborts the fetch.
    pc_mux = 1'b0; pc_hl = 5'h03; step();
    pc_mux = 1'b1; pc_hl = 5'h02; step();
    rst_n = 1'b0; #1;
    chk("mid_rst_data", 32'(rom_data), 32'h00);
    chk("mid_rst_vld", 32'(rom_valid), 32'd0);
    chk("mid_rst_rdy", 32'(ld_ready), 32'd1);
    step();
    rst_n = 1'b1;
    step();
    chk("post_rst_vld", 32'(rom_valid), 32'd0);
    fetch(10'h043, 3, 0, 1'b0, 1'b0);

`ifdef DG0045_ROM_PARITY_EN
    dut.mem[16][3] = ~dut.mem[16][3];
    fetch(10'h010, 1, 0, 1'b0, 1'b1);
    dut.mem[16][3] = ~dut.mem[16][3];
`endif
    fetch(10'h010, 1, 0, 1'b0, 1'b0);

    for (int it = 0; it < 60; it++) begin
      int a;
      bit hold;
      if ($urandom_range(0, 3) == 0) begin
        load(int'($urandom_range(0, 399)), 8'($urandom));
      end else begin
        a    = ($urandom_range(0, 9) == 0) ? int'($urandom_range(DEPTH, 1023))
                                           : int'($urandom_range(0, DEPTH - 1));
        hold = 1'($urandom);
        if (hold) begin
          ld_valid = 1'b1; ld_addr = 10'($urandom_range(0, DEPTH - 1)); ld_data = 8'($urandom);
        end
        fetch(a, int'($urandom_range(1, 3)), ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 3)) : 0,
              hold, 1'b0);
        ld_valid = 1'b0;
      end
    end

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end
endmodule
